// File: rtl/ulaplus_pal_pkg.sv
// Shared ULAplus constants, register-group encoding and greyscale helper.
package ulaplus_pal_pkg;

   localparam logic [15:0] ULAPLUS_ADDR_PORT = 16'hBF3B;
   localparam logic [15:0] ULAPLUS_DATA_PORT = 16'hFF3B;

   typedef enum logic [1:0] {
      UP_GRP_PAL  = 2'b00,
      UP_GRP_MODE = 2'b01
   } up_group_t;

   // GRB 3:3:2 colour -> green field replicated into every field
   function automatic logic [7:0] up_grey(input logic [7:0] color);
      return {color[7:5], color[7:5], color[7:6]};
   endfunction

endpackage

// File: rtl/cpu_bus.sv
// Z80-style CPU I/O bus as seen by the ULAplus block.
interface cpu_bus;
   logic        ioreq;
   logic        rd;
   logic        wr;
   logic [15:0] a;
   logic [7:0]  d;

   modport slave (input ioreq, input rd, input wr, input a, input d);
endinterface

// File: rtl/ulaplus_pal_ram.sv
// Palette register file: one write port, combinational CPU read port and a
// registered lookup read port (read-before-write on a same-edge write).
module ulaplus_pal_ram #(
   parameter  int DEPTH = 64,
   parameter  int W     = 8,
   localparam int IW    = $clog2(DEPTH)
) (
   input  logic          clk28,
   input  logic          rst_n,
   input  logic          we,
   input  logic [IW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [IW-1:0] cpu_addr,
   output logic [W-1:0]  cpu_data,
   input  logic [IW-1:0] pix_addr,
   output logic [W-1:0]  pix_data
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk28 or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         pix_data <= '0;
      end else begin
         if (we) mem[waddr] <= wdata;
         pix_data <= mem[pix_addr];
      end
   end

   assign cpu_data = mem[cpu_addr];

endmodule

// File: rtl/ulaplus_pal.sv
// ULAplus port decode, mode/palette registers and 2-cycle pixel colour lookup.
// Build option ULAPLUS_PAL_AUTOINC_EN: palette data writes post-increment addr[5:0].
module ulaplus_pal
   import ulaplus_pal_pkg::*;
#(
   parameter int          PAL_DEPTH = 64,
   parameter int          COLOR_W   = 8,
   parameter logic [15:0] ADDR_PORT = ULAPLUS_ADDR_PORT,
   parameter logic [15:0] DATA_PORT = ULAPLUS_DATA_PORT
) (
   input  logic               clk28,
   input  logic               rst_n,
   cpu_bus.slave              bus,
   input  logic               en,
   output logic [7:0]         d_out,
   output logic               d_out_active,
   output logic               up_en,
   output logic               grey,
   input  logic [5:0]         pix_idx,
   input  logic               pix_req,
   output logic [COLOR_W-1:0] pix_color,
   output logic               pix_valid
);

   localparam int IDX_W = $clog2(PAL_DEPTH);

   logic               addr_cs;
   logic               data_cs;
   logic               commit;
   logic               wr_done;
   logic               pal_we;
   logic               mode_we;
   logic [7:0]         addr_q;
   logic [7:0]         rd_mux;
   logic [COLOR_W-1:0] cpu_rd;
   logic [COLOR_W-1:0] pix_rd;
   logic               req_q;
   logic               unused_ok;

   assign addr_cs = en && bus.ioreq && (bus.a == ADDR_PORT);
   assign data_cs = en && bus.ioreq && (bus.a == DATA_PORT);
   // wr_done limits each I/O cycle to a single commit however long wr is held
   assign commit  = (addr_cs || data_cs) && bus.wr && !wr_done;
   assign pal_we  = commit && data_cs && (addr_q[7:6] == 2'(UP_GRP_PAL));
   assign mode_we = commit && data_cs && (addr_q[7:6] == 2'(UP_GRP_MODE));

   assign d_out_active = data_cs && bus.rd;
   assign unused_ok    = ^{pix_idx, bus.d};

   ulaplus_pal_ram #(
      .DEPTH (PAL_DEPTH),
      .W     (COLOR_W)
   ) u_ram (
      .clk28    (clk28),
      .rst_n    (rst_n),
      .we       (pal_we),
      .waddr    (addr_q[IDX_W-1:0]),
      .wdata    (bus.d[COLOR_W-1:0]),
      .cpu_addr (addr_q[IDX_W-1:0]),
      .cpu_data (cpu_rd),
      .pix_addr (pix_idx[IDX_W-1:0]),
      .pix_data (pix_rd)
   );

   always_comb begin
      rd_mux = 8'hFF;
      if (addr_q[7:6] == 2'(UP_GRP_PAL))
         rd_mux = 8'(cpu_rd);
      else if (addr_q[7:6] == 2'(UP_GRP_MODE))
         rd_mux = {6'b0, grey, up_en};
   end

   always_ff @(posedge clk28 or negedge rst_n) begin
      if (!rst_n) begin
         addr_q  <= 8'h00;
         wr_done <= 1'b0;
         up_en   <= 1'b0;
         grey    <= 1'b0;
         d_out   <= 8'h00;
      end else begin
         d_out <= rd_mux;
         if (!bus.ioreq)
            wr_done <= 1'b0;
         else if (commit)
            wr_done <= 1'b1;
         if (commit && addr_cs)
            addr_q <= bus.d;
`ifdef ULAPLUS_PAL_AUTOINC_EN
         else if (pal_we)
            addr_q[5:0] <= addr_q[5:0] + 6'd1;
`endif
         if (mode_we) begin
            up_en <= bus.d[0];
            grey  <= bus.d[1];
         end
      end
   end

   // Stage 1 is the RAM's registered read; stage 2 applies greyscale.
   always_ff @(posedge clk28 or negedge rst_n) begin
      if (!rst_n) begin
         req_q     <= 1'b0;
         pix_valid <= 1'b0;
         pix_color <= '0;
      end else begin
         req_q     <= pix_req;
         pix_valid <= req_q;
         pix_color <= grey ? COLOR_W'(up_grey(8'(pix_rd))) : pix_rd;
      end
   end

endmodule
